// File: rtl/fod_spi_regbank.sv
// fod_spi_regbank: SPI-slave (mode 0, 24-bit frames) register bank for NCH
// fractional-output-divider channels. Writes land in per-channel shadow
// registers; an APPLY write (ADDR 0x7F) copies shadow to active and pulses
// FREQ_HOP. All outputs come from the active copies only.
// Optional MISO readback of shadow registers: define FOD_SPI_READBACK_EN.
module fod_spi_regbank #(
    parameter int unsigned NCH     = 1,
    parameter int unsigned WI      = 7,
    parameter int unsigned WF      = 16,
    parameter int unsigned FCW_RST = 311296
) (
    input  logic                   CLK,
    input  logic                   NRST,
    input  logic                   SCK,
    input  logic                   CS_N,
    input  logic                   MOSI,
    output logic                   MISO,
    output logic [NCH*(WI+WF)-1:0] FCW_FOD,
    output logic [NCH*14-1:0]      CTRL,
    output logic [NCH*10-1:0]      PHASE_CTRL,
    output logic [NCH*10-1:0]      KS,
    output logic [NCH*15-1:0]      KBCD,
    output logic [NCH*30-1:0]      KDTC_INIT,
    output logic [NCH-1:0]         FREQ_HOP
);

    localparam int unsigned  W         = WI + WF;
    localparam logic [W-1:0] FCW_RST_V = W'(FCW_RST);
    // PCALI_EN, RT_EN set; PSEG = 3; CALIORDER = 3
    localparam logic [13:0]  CTRL_RST  = 14'b000_11_11_0010010;
    localparam logic [9:0]   KS_RST    = {5'd8, 5'd0};
    // KD = -5, KC = -3, KB = 0 (5-bit two's complement)
    localparam logic [14:0]  KBCD_RST  = {5'h1B, 5'h1D, 5'h00};
    localparam logic [9:0]   KDTCB_RST = 10'd390;
    localparam logic [9:0]   KDTCC_RST = 10'd195;
    localparam logic [9:0]   KDTCD_RST = 10'd0;

    typedef enum logic [1:0] {S_IDLE, S_CMD, S_DATA, S_DONE} state_t;

    state_t      state, state_nxt;
    logic [1:0]  sck_sync, cs_sync, mosi_sync;
    logic        sck_prev;
    logic        sck_s, cs_s, mosi_s, sck_rise;
    logic        shift_en, frame_end;
    logic [4:0]  bit_cnt;
    logic [22:0] shreg;
    logic        wr_vld;
    logic [6:0]  wr_addr;
    logic [15:0] wr_data;
    logic        apply_hit;

    assign sck_s    = sck_sync[1];
    assign cs_s     = cs_sync[1];
    assign mosi_s   = mosi_sync[1];
    assign sck_rise = sck_s & ~sck_prev;
    assign apply_hit = wr_vld && (wr_addr == 7'h7F);

    // two-flop synchronisers for the SPI pins plus SCK history for edge detect
    always_ff @(posedge CLK) begin
        if (!NRST) begin
            sck_sync  <= '0;
            cs_sync   <= '1;
            mosi_sync <= '0;
            sck_prev  <= 1'b0;
        end else begin
            sck_sync  <= {sck_sync[0], SCK};
            cs_sync   <= {cs_sync[0], CS_N};
            mosi_sync <= {mosi_sync[0], MOSI};
            sck_prev  <= sck_s;
        end
    end

    // frame FSM state register
    always_ff @(posedge CLK) begin
        if (!NRST) state <= S_IDLE;
        else       state <= state_nxt;
    end

    // frame FSM next-state: CS_N high always returns to IDLE
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (!cs_s) state_nxt = S_CMD;
            S_CMD: begin
                if (cs_s)                               state_nxt = S_IDLE;
                else if (sck_rise && bit_cnt == 5'd7)   state_nxt = S_DATA;
            end
            S_DATA: begin
                if (cs_s)                               state_nxt = S_IDLE;
                else if (sck_rise && bit_cnt == 5'd23)  state_nxt = S_DONE;
            end
            S_DONE: if (cs_s) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

`ifdef FOD_SPI_READBACK_EN
    logic sck_fall, cmd_end, tx_shift;
    assign sck_fall = ~sck_s & sck_prev;
`endif

    // frame FSM outputs: bit shifting is only live in CMD/DATA with CS_N low
    always_comb begin
        shift_en  = sck_rise && !cs_s && (state == S_CMD || state == S_DATA);
        frame_end = shift_en && (state == S_DATA) && (bit_cnt == 5'd23);
`ifdef FOD_SPI_READBACK_EN
        cmd_end   = shift_en && (state == S_CMD) && (bit_cnt == 5'd7);
        tx_shift  = sck_fall && !cs_s && (state == S_DATA);
`endif
    end

    // receive shifter, bit counter and decoded write request
    always_ff @(posedge CLK) begin
        if (!NRST) begin
            bit_cnt <= '0;
            shreg   <= '0;
            wr_vld  <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
        end else begin
            wr_vld <= frame_end && shreg[22];
            if (frame_end) begin
                wr_addr <= shreg[21:15];
                wr_data <= {shreg[14:0], mosi_s};
            end
            if (state == S_IDLE) bit_cnt <= '0;
            else if (shift_en)   bit_cnt <= bit_cnt + 5'd1;
            if (shift_en) shreg <= {shreg[21:0], mosi_s};
        end
    end

`ifdef FOD_SPI_READBACK_EN
    logic [NCH:0][15:0] rd_acc;
    logic [6:0]         rd_addr;
    logic [15:0]        tx_sr;
    logic               miso_q;
    assign rd_addr   = {shreg[5:0], mosi_s};
    assign rd_acc[0] = '0;
`endif

    for (genvar g = 0; g < NCH; g++) begin : g_ch
        logic [W-1:0] sh_fcw, act_fcw;
        logic [13:0]  sh_ctrl, act_ctrl;
        logic [9:0]   sh_phase, act_phase, sh_ks, act_ks;
        logic [14:0]  sh_kbcd, act_kbcd;
        logic [9:0]   sh_kb, sh_kc, sh_kd, act_kb, act_kc, act_kd;
        logic         hop, sel, apply;

        assign sel   = wr_vld && (wr_addr[6:4] == 3'(g));
        assign apply = apply_hit && (wr_data[g] || wr_data[15]);

        // shadow registers: written by decoded frames, excess data bits dropped
        always_ff @(posedge CLK) begin
            if (!NRST) begin
                sh_fcw   <= FCW_RST_V;
                sh_ctrl  <= CTRL_RST;
                sh_phase <= '0;
                sh_ks    <= KS_RST;
                sh_kbcd  <= KBCD_RST;
                sh_kb    <= KDTCB_RST;
                sh_kc    <= KDTCC_RST;
                sh_kd    <= KDTCD_RST;
            end else if (sel) begin
                case (wr_addr[3:0])
                    4'h0: sh_fcw[15:0]   <= wr_data;
                    4'h1: sh_fcw[W-1:16] <= wr_data[W-17:0];
                    4'h2: sh_ctrl        <= wr_data[13:0];
                    4'h3: sh_phase       <= wr_data[9:0];
                    4'h4: sh_ks          <= wr_data[9:0];
                    4'h5: sh_kbcd        <= wr_data[14:0];
                    4'h6: sh_kb          <= wr_data[9:0];
                    4'h7: sh_kc          <= wr_data[9:0];
                    4'h8: sh_kd          <= wr_data[9:0];
                    default: ;
                endcase
            end
        end

        // active registers and hop pulse: updated together on APPLY
        always_ff @(posedge CLK) begin
            if (!NRST) begin
                act_fcw   <= FCW_RST_V;
                act_ctrl  <= CTRL_RST;
                act_phase <= '0;
                act_ks    <= KS_RST;
                act_kbcd  <= KBCD_RST;
                act_kb    <= KDTCB_RST;
                act_kc    <= KDTCC_RST;
                act_kd    <= KDTCD_RST;
                hop       <= 1'b0;
            end else begin
                hop <= apply;
                if (apply) begin
                    act_fcw   <= sh_fcw;
                    act_ctrl  <= sh_ctrl;
                    act_phase <= sh_phase;
                    act_ks    <= sh_ks;
                    act_kbcd  <= sh_kbcd;
                    act_kb    <= sh_kb;
                    act_kc    <= sh_kc;
                    act_kd    <= sh_kd;
                end
            end
        end

        assign FCW_FOD[g*W +: W]     = act_fcw;
        assign CTRL[g*14 +: 14]      = act_ctrl;
        assign PHASE_CTRL[g*10 +: 10] = act_phase;
        assign KS[g*10 +: 10]        = act_ks;
        assign KBCD[g*15 +: 15]      = act_kbcd;
        assign KDTC_INIT[g*30 +: 30] = {act_kd, act_kc, act_kb};
        assign FREQ_HOP[g]           = hop;

`ifdef FOD_SPI_READBACK_EN
        logic [15:0] rd_word;
        // per-channel read mux, OR-chained across channels
        always_comb begin
            rd_word = '0;
            if (rd_addr[6:4] == 3'(g)) begin
                case (rd_addr[3:0])
                    4'h0: rd_word = sh_fcw[15:0];
                    4'h1: rd_word = 16'(sh_fcw[W-1:16]);
                    4'h2: rd_word = 16'(sh_ctrl);
                    4'h3: rd_word = 16'(sh_phase);
                    4'h4: rd_word = 16'(sh_ks);
                    4'h5: rd_word = 16'(sh_kbcd);
                    4'h6: rd_word = 16'(sh_kb);
                    4'h7: rd_word = 16'(sh_kc);
                    4'h8: rd_word = 16'(sh_kd);
                    default: rd_word = '0;
                endcase
            end
        end
        assign rd_acc[g+1] = rd_acc[g] | rd_word;
`endif
    end

`ifdef FOD_SPI_READBACK_EN
    // read data loaded after the command byte, shifted out MSB first on SCK falls
    always_ff @(posedge CLK) begin
        if (!NRST || cs_s) begin
            tx_sr  <= '0;
            miso_q <= 1'b0;
        end else if (cmd_end) begin
            tx_sr <= shreg[6] ? '0 : rd_acc[NCH];
        end else if (tx_shift) begin
            miso_q <= tx_sr[15];
            tx_sr  <= {tx_sr[14:0], 1'b0};
        end
    end
    assign MISO = miso_q;
`else
    assign MISO = 1'b0;
`endif

endmodule

// File: tb/tb_fod_spi_regbank.sv
// tb_fod_spi_regbank: directed SPI frames against fod_spi_regbank (NCH=2).
// A register-level model (shadow/active word arrays) predicts the outputs;
// a monitor compares them on every falling CLK edge. Read checks are built
// only when FOD_SPI_READBACK_EN is defined.
module tb_fod_spi_regbank;

    localparam int NCH        = 2;
    localparam int W          = 23;
    localparam int FCW_RST_TB = 311296;

    logic                 CLK = 1'b0;
    logic                 NRST, SCK, CS_N, MOSI, MISO;
    logic [NCH*W-1:0]     FCW_FOD;
    logic [NCH*14-1:0]    CTRL;
    logic [NCH*10-1:0]    PHASE_CTRL, KS;
    logic [NCH*15-1:0]    KBCD;
    logic [NCH*30-1:0]    KDTC_INIT;
    logic [NCH-1:0]       FREQ_HOP;

    fod_spi_regbank #(.NCH(NCH), .WI(7), .WF(16), .FCW_RST(FCW_RST_TB)) dut (
        .CLK(CLK), .NRST(NRST), .SCK(SCK), .CS_N(CS_N), .MOSI(MOSI), .MISO(MISO),
        .FCW_FOD(FCW_FOD), .CTRL(CTRL), .PHASE_CTRL(PHASE_CTRL), .KS(KS),
        .KBCD(KBCD), .KDTC_INIT(KDTC_INIT), .FREQ_HOP(FREQ_HOP)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [NCH*W-1:0]  fcw;
        logic [NCH*14-1:0] ctrl;
        logic [NCH*10-1:0] phase;
        logic [NCH*10-1:0] ks;
        logic [NCH*15-1:0] kbcd;
        logic [NCH*30-1:0] kdtc;
    } outs_t;

    typedef logic [15:0] regs_t [NCH][9];

    regs_t          m_sh, m_cur, m_nxt;
    logic [NCH-1:0] exp_hop, hop_last;
    int             hop_cyc, n_chk, n_pass;
    logic           hop_seen, win, mon_en;
    logic [15:0]    rx;
    outs_t          dut_o;

    assign dut_o = {FCW_FOD, CTRL, PHASE_CTRL, KS, KBCD, KDTC_INIT};

    task automatic chk(input string name, input logic [255:0] got, input logic [255:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    endtask

    function automatic int reg_w(input int r);
        case (r)
            0: return 16;  1: return 7;   2: return 14;
            3: return 10;  4: return 10;  5: return 15;
            default: return 10;
        endcase
    endfunction

    // reset values built from the documented fields
    function automatic logic [15:0] reg_rst(input int r);
        case (r)
            0: return 16'(FCW_RST_TB & 32'hFFFF);
            1: return 16'(FCW_RST_TB >> 16);
            2: return 16'((1 << 1) | (1 << 4) | (3 << 7) | (3 << 9));
            4: return 16'(8 << 5);
            5: return 16'((((-5) & 31) << 10) | (((-3) & 31) << 5));
            6: return 16'(390);
            7: return 16'(195);
            default: return 16'(0);
        endcase
    endfunction

    function automatic outs_t pack(input regs_t a);
        outs_t o;
        o = '0;
        for (int c = 0; c < NCH; c++) begin
            o.fcw[c*W +: W]     = W'({a[c][1], a[c][0]});
            o.ctrl[c*14 +: 14]  = 14'(a[c][2]);
            o.phase[c*10 +: 10] = 10'(a[c][3]);
            o.ks[c*10 +: 10]    = 10'(a[c][4]);
            o.kbcd[c*15 +: 15]  = 15'(a[c][5]);
            o.kdtc[c*30 +: 30]  = {10'(a[c][8]), 10'(a[c][7]), 10'(a[c][6])};
        end
        return o;
    endfunction

    task automatic m_reset();
        for (int c = 0; c < NCH; c++)
            for (int r = 0; r < 9; r++) m_sh[c][r] = reg_rst(r);
        m_cur = m_sh;
        m_nxt = m_sh;
    endtask

    task automatic m_write(input logic [6:0] addr, input logic [15:0] data);
        int ch, r;
        ch = int'(addr >> 4);
        r  = int'(addr & 7'h0F);
        if (addr == 7'h7F) begin
            for (int c = 0; c < NCH; c++)
                if (((data >> c) & 16'd1) != 0 || data[15]) begin
                    for (int k = 0; k < 9; k++) m_nxt[c][k] = m_sh[c][k];
                    exp_hop = exp_hop | NCH'(1 << c);
                end
        end else if (ch < NCH && r < 9) begin
            m_sh[ch][r] = data & 16'((32'd1 << reg_w(r)) - 1);
        end
    endtask

    function automatic logic [15:0] m_read(input logic [6:0] addr);
        int ch, r;
        ch = int'(addr >> 4);
        r  = int'(addr & 7'h0F);
        if (ch < NCH && r < 9) return m_sh[ch][r];
        return 16'h0000;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic spi_bits(input logic [23:0] fr, input int nbits, output logic [15:0] rxo);
        rxo = '0;
        for (int i = 0; i < nbits; i++) begin
            MOSI = fr[23-i];
            tick(8);
            SCK = 1'b1;
            if (i >= 8) rxo = {rxo[14:0], MISO};
            tick(8);
            SCK = 1'b0;
        end
    endtask

    // one SPI transaction with model update and hop-pulse accounting
    task automatic frame(input logic [6:0] addr, input logic rw, input logic [15:0] data,
                         input int nbits, input int extra);
        m_nxt    = m_cur;
        exp_hop  = '0;
        hop_seen = 1'b0;
        hop_cyc  = 0;
        if (nbits == 24 && rw) m_write(addr, data);
        win  = 1'b1;
        CS_N = 1'b0;
        tick(4);
        spi_bits({rw, addr, data}, nbits, rx);
        for (int e = 0; e < extra; e++) begin
            tick(8); SCK = 1'b1; tick(8); SCK = 1'b0;
        end
        tick(8);
        CS_N = 1'b1;
        MOSI = 1'b0;
        tick(12);
        chk("hop_cycles", 256'(hop_cyc), (exp_hop != '0) ? 256'd1 : 256'd0);
        m_cur = m_nxt;
        win   = 1'b0;
    endtask

    task automatic wr(input logic [6:0] addr, input logic [15:0] data);
        frame(addr, 1'b1, data, 24, 0);
    endtask

`ifdef FOD_SPI_READBACK_EN
    task automatic rd(input logic [6:0] addr, input string name);
        logic [15:0] e;
        e = m_read(addr);
        frame(addr, 1'b0, 16'h0000, 24, 0);
        chk(name, 256'(rx), 256'(e));
    endtask
`endif

    // per-cycle compare of every output against the model
    always @(negedge CLK) begin
        if (mon_en) begin
            if (win && FREQ_HOP != '0) begin
                hop_cyc++;
                hop_seen = 1'b1;
                hop_last = FREQ_HOP;
                chk("hop_value", 256'(FREQ_HOP), 256'(exp_hop));
                chk("outs_at_hop", 256'(dut_o), 256'(pack(m_nxt)));
            end else if (win) begin
                chk(hop_seen ? "outs_after_hop" : "outs_before_hop", 256'(dut_o),
                    hop_seen ? 256'(pack(m_nxt)) : 256'(pack(m_cur)));
            end else begin
                chk("hop_idle", 256'(FREQ_HOP), 256'd0);
                chk("outs_idle", 256'(dut_o), 256'(pack(m_cur)));
            end
`ifndef FOD_SPI_READBACK_EN
            chk("miso_zero", 256'(MISO), 256'd0);
`endif
        end
    end

    initial begin
        #3ms;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1);
    end

    initial begin
        n_chk = 0; n_pass = 0; hop_cyc = 0; hop_seen = 1'b0; hop_last = '0;
        exp_hop = '0; win = 1'b0; mon_en = 1'b0;
        NRST = 1'b0; SCK = 1'b0; CS_N = 1'b1; MOSI = 1'b0;
        m_reset();
        tick(4);
        NRST = 1'b1;
        tick(1);
        mon_en = 1'b1;
        tick(2);

        // reset state, hand-computed
        chk("rst_fcw0", 256'(FCW_FOD[22:0]), 256'd311296);
        chk("rst_pcali_en", 256'(CTRL[1]), 256'd1);
        chk("rst_pseg", 256'(CTRL[8:7]), 256'd3);
        chk("rst_kdtcb", 256'(KDTC_INIT[9:0]), 256'd390);
        chk("rst_kbcd", 256'(KBCD[14:0]), 256'({5'b11011, 5'b11101, 5'b00000}));
        chk("rst_hop", 256'(FREQ_HOP), 256'd0);

`ifdef FOD_SPI_READBACK_EN
        rd(7'h05, "rd_kbcd_rst");
        chk("rd_kbcd_lit", 256'(rx), 256'h6FA0);
        rd(7'h0F, "rd_unmapped");
        rd(7'h11, "rd_ch1_fcwhi");
`endif

        // FCW update only visible after APPLY
        wr(7'h00, 16'h4000);
        chk("fcw_before_apply", 256'(FCW_FOD[22:0]), 256'd311296);
        wr(7'h01, 16'h004C);
        wr(7'h7F, 16'h0001);
        chk("fcw_applied", 256'(FCW_FOD[22:0]), 256'h4C4000);
        chk("fcw_ch1_kept", 256'(FCW_FOD[45:23]), 256'd311296);
        chk("hop_ch0", 256'(hop_last), 256'b01);

        // channel 1 control word
        wr(7'h12, 16'h0021);
        wr(7'h7F, 16'h0002);
        chk("ch1_sys_en", 256'(CTRL[14]), 256'd1);
        chk("ch1_dtccali_en", 256'(CTRL[19]), 256'd1);
        chk("ch0_ctrl_kept", 256'(CTRL[13:0]), 256'h792);
        chk("hop_ch1", 256'(hop_last), 256'b10);

        // aborted write after 12 bits, then broadcast APPLY
        frame(7'h03, 1'b1, 16'h0155, 12, 0);
        wr(7'h7F, 16'h8000);
        chk("abort_phase", 256'(PHASE_CTRL), 256'd0);

        // width truncation, unmapped writes, read frame, trailing SCK in DONE
        wr(7'h03, 16'hFFFF);
        wr(7'h15, 16'hFFFF);
        wr(7'h06, 16'h1234);
        wr(7'h09, 16'hAAAA);
        wr(7'h23, 16'h5555);
        wr(7'h0F, 16'h1111);
        wr(7'h7E, 16'h2222);
        frame(7'h00, 1'b0, 16'hBEEF, 24, 0);
        frame(7'h04, 1'b1, 16'h0033, 24, 8);
`ifdef FOD_SPI_READBACK_EN
        rd(7'h15, "rd_kbcd_trunc");
        rd(7'h23, "rd_unmapped_ch2");
`endif
        wr(7'h7F, 16'h0001);
        chk("phase_trunc", 256'(PHASE_CTRL[9:0]), 256'h3FF);
        chk("kdtcb_trunc", 256'(KDTC_INIT[9:0]), 256'h234);
        chk("ks_written", 256'(KS[9:0]), 256'h033);
        chk("ch1_kbcd_pending", 256'(KBCD[29:15]), 256'h6FA0);
        wr(7'h7F, 16'h0002);
        chk("ch1_kbcd_applied", 256'(KBCD[29:15]), 256'h7FFF);

        // reset in the middle of a data phase after pending shadow writes
        wr(7'h13, 16'h00AA);
        wr(7'h04, 16'h0011);
        CS_N = 1'b0;
        tick(4);
        spi_bits({1'b1, 7'h08, 16'h0155}, 13, rx);
        mon_en = 1'b0;
        NRST = 1'b0;
        tick(3);
        CS_N = 1'b1; SCK = 1'b0; MOSI = 1'b0;
        m_reset();
        NRST = 1'b1;
        tick(2);
        mon_en = 1'b1;
        wr(7'h7F, 16'h8000);
        chk("rst_mid_fcw", 256'(FCW_FOD[22:0]), 256'd311296);
        chk("rst_mid_phase", 256'(PHASE_CTRL), 256'd0);
        chk("rst_mid_ks", 256'(KS[9:0]), 256'h100);
        chk("hop_all", 256'(hop_last), 256'b11);
`ifdef FOD_SPI_READBACK_EN
        rd(7'h13, "rd_after_reset");
`endif

        // first full frame after the mid-frame reset
        wr(7'h18, 16'h0123);
        wr(7'h7F, 16'h0002);
        chk("post_rst_kdtcd", 256'(KDTC_INIT[59:50]), 256'h123);

        tick(4);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
